sync_fifo_v3: RTL and testbench
===============================

Name: sync_fifo_v3

Overview:
- Single-clock, parametrised FIFO for intra-domain buffering between the line-buffer and the PE-array feeders. It is the same-clock successor of the dual-clock FIFO.
- Adds runtime-programmable almost thresholds, a selectable read mode (first-word-fall-through or registered), sticky overflow/underflow flags, synchronous flush, a peak-level tracker, and hysteretic pre-fill status.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- FIFO_DEPTH, 16, number of entries; must be a power of 2 and >= 4.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), memory index width; derived, never overridden.
- FWFT, 1, read mode. 1 = first-word-fall-through (combinational head). 0 = registered read with 1-cycle latency.
- PRE_FILL_LEVEL, FIFO_DEPTH/2, level at which pre_fill_done sets; range 1..FIFO_DEPTH.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous empty-the-FIFO command.
- clr_err  in  1  clears overflow, underflow and peak_level.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write payload.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  read payload.
- rd_valid  out  1  rd_data qualifier.
- af_thresh  in  ADDR_WIDTH+1  almost-full threshold.
- ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold.
- full  out  1  level == FIFO_DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= af_thresh.
- almost_empty  out  1  level <= ae_thresh.
- level  out  ADDR_WIDTH+1  current occupancy.
- peak_level  out  ADDR_WIDTH+1  maximum occupancy since the last clear.
- pre_fill_done  out  1  pre-fill status with hysteresis.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high (ports named clk and rst).
  - On rst: pointers, level, peak_level, pre_fill_done, overflow, underflow and rd_valid are all 0. Registered rd_data (FWFT=0) is 0.
  - Memory contents are not reset.
- Pointers and level:
  - Binary pointers, ADDR_WIDTH+1 bits, wrapping naturally modulo 2*FIFO_DEPTH.
  - level is a register: level = wr_ptr - rd_ptr, computed modulo 2^(ADDR_WIDTH+1).
- Write and read acceptance:
  - Write accepted iff wr_en && !full && !flush. On accept, mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data and wr_ptr increments.
  - Read accepted iff rd_en && !empty && !flush.
  - There is no pass-through. A write to an empty FIFO cannot be read in the same cycle. A read from a full FIFO does not free space for a write in the same cycle.
  - Simultaneous accepted write and read leave level unchanged.
- Flag timing:
  - All status flags are combinational from the registered level and the thresholds.
  - An accepted write at edge N deasserts empty after edge N.
  - An accepted read at edge N frees a slot, so full deasserts after edge N.
- FWFT=1 read mode:
  - rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]] and rd_valid = !empty.
  - A read accept advances to the next entry.
- FWFT=0 read mode:
  - On read accept, rd_data is registered from mem[rd_ptr] and rd_valid = 1 on the next cycle; otherwise rd_valid = 0.
  - rd_data holds its last value when not reading.
- Threshold edge cases:
  - af_thresh = 0 gives almost_full constantly 1.
  - ae_thresh >= FIFO_DEPTH gives almost_empty constantly 1.
  - Thresholds may change at any cycle and take effect combinationally.
- pre_fill_done:
  - Sets on the cycle after level >= PRE_FILL_LEVEL.
  - Clears only when level returns to 0.
  - Holds between those points (hysteresis, no chatter).
- Error flags:
  - overflow sets on wr_en && full. underflow sets on rd_en && empty.
  - Neither sets while flush is high.
  - Both clear on clr_err or rst. If clr_err and a new error event occur in the same cycle, set wins.
- peak_level:
  - Register updated to max(peak_level, next level).
  - clr_err loads it with the current level.
- flush:
  - Next cycle: pointers, level, pre_fill_done and rd_valid are 0.
  - Error flags and peak_level are retained.
  - Concurrent wr_en/rd_en are dropped.
  - rst has priority over flush.
- Reset mid-operation: behaves like flush, and additionally clears the errors, peak_level and registered rd_data.

Decomposition:
- Package fifo_pkg:
  - FIFO_MIN_DEPTH = 4.
  - Function is_pow2 for parameter checks.
  - typedef fifo_status_t packed struct {full, almost_full, empty, almost_empty, overflow, underflow}.
- Sub-module fifo_ram:
  - 1W1R memory with synchronous write.
  - Read mode set by parameter REG_OUT: 0 = combinational, 1 = registered.
  - Instantiated with REG_OUT = !FWFT.
- Top level holds the pointers, level, flags and trackers.

Test Plan:
- Fill/drain, FWFT=1, DEPTH=16: reset, then write 0x01..0x10 on 16 consecutive cycles.
  - full=1 and level=16 after the last write.
  - Read 16 times: data 0x01..0x10 in order, then empty=1.
- Error flags: write 0xAA while full, then read while empty.
  - overflow=1, data not stored, level stays 16.
  - underflow=1, level stays 0.
  - clr_err clears both flags; peak_level becomes the current level.
- Registered read mode, FWFT=0: write 0x5A, then pulse rd_en.
  - rd_valid=1 and rd_data=0x5A exactly 1 cycle after the accepted read; rd_valid=0 otherwise.
- Simultaneous read/write at level 8: wr_en=rd_en=1 for 20 cycles.
  - level stays 8; data ordering preserved across the pointer wrap.
- Thresholds and pre-fill: af=14, ae=2.
  - almost_full asserts at level 14; almost_empty deasserts at level 3.
  - pre_fill_done sets at 8, holds while draining to 1, clears at 0.
- flush and rst mid-stream at level 10 with wr_en=1:
  - flush gives level=0 and empty=1 next cycle, errors retained, the write is dropped.
  - rst gives all outputs at their reset values.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and parameter helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int unsigned FIFO_MIN_DEPTH = 4;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// 1W1R storage array; read port is combinational or registered depending on REG_OUT.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter bit          REG_OUT    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (REG_OUT) begin : g_reg_out
    logic [DATA_WIDTH-1:0] rdata_q;

    // Output register holds its value between reads.
    always_ff @(posedge clk) begin
      if (rst)     rdata_q <= '0;
      else if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
  end else begin : g_comb_out
    logic unused_ctrl;
    assign unused_ctrl = rst ^ re;
    assign rdata       = mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_v3.sv
// Single-clock FIFO with programmable almost thresholds, sticky errors, flush,
// peak-level tracking and hysteretic pre-fill status.
module sync_fifo_v3
  import fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH     = 8,
  parameter  int unsigned FIFO_DEPTH     = 16,
  localparam int unsigned ADDR_WIDTH     = $clog2(FIFO_DEPTH),
  parameter  bit          FWFT           = 1'b1,
  parameter  int unsigned PRE_FILL_LEVEL = FIFO_DEPTH / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic [ADDR_WIDTH:0]   peak_level,
  output logic                  pre_fill_done,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned LW = ADDR_WIDTH + 1;

  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < FIFO_MIN_DEPTH) begin : g_bad_depth
    $error("sync_fifo_v3: FIFO_DEPTH must be a power of 2 and >= %0d", FIFO_MIN_DEPTH);
  end
  if (PRE_FILL_LEVEL < 1 || PRE_FILL_LEVEL > FIFO_DEPTH) begin : g_bad_prefill
    $error("sync_fifo_v3: PRE_FILL_LEVEL out of range");
  end

  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] peak_q, peak_d;
  logic          pre_fill_q, pre_fill_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wr_acc, rd_acc;
  fifo_status_t  status_c;

  // Status flags decode from the registered level only.
  always_comb begin
    status_c              = '0;
    status_c.full         = (level_q == LW'(FIFO_DEPTH));
    status_c.empty        = (level_q == '0);
    status_c.almost_full  = (level_q >= af_thresh);
    status_c.almost_empty = (level_q <= ae_thresh);
    status_c.overflow     = ovf_q;
    status_c.underflow    = udf_q;
  end

  always_comb begin
    wr_acc     = wr_en && !status_c.full  && !flush;
    rd_acc     = rd_en && !status_c.empty && !flush;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pre_fill_d = pre_fill_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    rd_valid_d = rd_acc;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + LW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + LW'(1);
    end
    level_d = wr_ptr_d - rd_ptr_d;

    // Sets a cycle after reaching the pre-fill level, drops only once drained.
    if (level_d == '0)                       pre_fill_d = 1'b0;
    else if (level_q >= LW'(PRE_FILL_LEVEL)) pre_fill_d = 1'b1;

    // A new error event in the same cycle as clr_err wins.
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_en && status_c.full  && !flush) ovf_d = 1'b1;
    if (rd_en && status_c.empty && !flush) udf_d = 1'b1;

    if (clr_err)                peak_d = level_q;
    else if (level_d > peak_q)  peak_d = level_d;
    else                        peak_d = peak_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      peak_q     <= '0;
      pre_fill_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      peak_q     <= peak_d;
      pre_fill_q <= pre_fill_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_OUT    (!FWFT)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (rd_data)
  );

  assign rd_valid      = FWFT ? !status_c.empty : rd_valid_q;
  assign full          = status_c.full;
  assign empty         = status_c.empty;
  assign almost_full   = status_c.almost_full;
  assign almost_empty  = status_c.almost_empty;
  assign overflow      = status_c.overflow;
  assign underflow     = status_c.underflow;
  assign level         = level_q;
  assign peak_level    = peak_q;
  assign pre_fill_done = pre_fill_q;

endmodule

// File: tb/tb_sync_fifo_v3.sv
// Self-checking bench: FWFT and registered-read instances driven in lockstep
// against a queue scoreboard plus a threshold vector table.
module tb_sync_fifo_v3;

  logic       clk = 1'b0;
  logic       rst = 1'b0, flush = 1'b0, clr_err = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic [4:0] af_thresh = 5'd14, ae_thresh = 5'd2;

  logic [7:0] f_rd_data, r_rd_data;
  logic       f_rd_valid, r_rd_valid, f_full, r_full, f_empty, r_empty;
  logic       f_af, r_af, f_ae, r_ae, f_pfd, r_pfd, f_ovf, r_ovf, f_udf, r_udf;
  logic [4:0] f_level, r_level, f_peak, r_peak;

  always #5 clk = ~clk;

  sync_fifo_v3 #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .level(f_level), .peak_level(f_peak), .pre_fill_done(f_pfd),
    .overflow(f_ovf), .underflow(f_udf));

  sync_fifo_v3 #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1'b0)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(r_rd_data), .rd_valid(r_rd_valid), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .full(r_full), .empty(r_empty), .almost_full(r_af),
    .almost_empty(r_ae), .level(r_level), .peak_level(r_peak), .pre_fill_done(r_pfd),
    .overflow(r_ovf), .underflow(r_udf));

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  int         m_peak = 0;
  bit         m_ovf = 0, m_udf = 0, m_pfd = 0, m_rv_r = 0;
  logic [7:0] m_rdata_r = '0;

  typedef struct {
    logic [4:0] af;
    logic [4:0] ae;
    bit         wr;
    bit         rd;
    logic [7:0] d;
    int         exp_level;
    bit         exp_af;
    bit         exp_ae;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n = sb.size();
    chk("f_level", int'(f_level), n);
    chk("r_level", int'(r_level), n);
    chk("full", int'(f_full), int'(n == 16));
    chk("empty", int'(f_empty), int'(n == 0));
    chk("almost_full", int'(f_af), int'(n >= int'(af_thresh)));
    chk("almost_empty", int'(f_ae), int'(n <= int'(ae_thresh)));
    chk("overflow", int'(f_ovf), int'(m_ovf));
    chk("underflow", int'(f_udf), int'(m_udf));
    chk("peak_level", int'(f_peak), m_peak);
    chk("pre_fill_done", int'(f_pfd), int'(m_pfd));
    chk("fwft_rd_valid", int'(f_rd_valid), int'(n != 0));
    chk("reg_rd_valid", int'(r_rd_valid), int'(m_rv_r));
    chk("reg_rd_data", int'(r_rd_data), int'(m_rdata_r));
  endtask

  // One clock of stimulus; the scoreboard predicts acceptance from its own occupancy.
  task automatic cycle(input bit wr, input logic [7:0] d, input bit rd,
                       input bit fl, input bit clr, input bit r);
    int         pre  = sb.size();
    bit         wacc = wr && (pre < 16) && !fl;
    bit         racc = rd && (pre > 0) && !fl;
    logic [7:0] head = '0;
    if (racc) begin
      head = sb[0];
      chk("fwft_rd_data", int'(f_rd_data), int'(head));
    end
    rst = r; flush = fl; clr_err = clr; wr_en = wr; wr_data = d; rd_en = rd;
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      m_peak = 0; m_ovf = 0; m_udf = 0; m_pfd = 0; m_rv_r = 0; m_rdata_r = '0;
    end else begin
      if (wr && pre == 16 && !fl) m_ovf = 1;
      else if (clr)               m_ovf = 0;
      if (rd && pre == 0 && !fl)  m_udf = 1;
      else if (clr)               m_udf = 0;
      m_rv_r = racc;
      if (racc) m_rdata_r = head;
      if (fl) sb.delete();
      else begin
        if (racc) void'(sb.pop_front());
        if (wacc) sb.push_back(d);
      end
      if (sb.size() == 0) m_pfd = 0;
      else if (pre >= 8)  m_pfd = 1;
      if (clr)                    m_peak = pre;
      else if (sb.size() > m_peak) m_peak = sb.size();
    end
    rst = 0; flush = 0; clr_err = 0; wr_en = 0; rd_en = 0;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{af: 5'd0,  ae: 5'd2,  wr: 0, rd: 0, d: 8'h00, exp_level: 14, exp_af: 1, exp_ae: 0};
    tbl[1] = '{af: 5'd15, ae: 5'd2,  wr: 1, rd: 0, d: 8'h77, exp_level: 15, exp_af: 1, exp_ae: 0};
    tbl[2] = '{af: 5'd16, ae: 5'd2,  wr: 0, rd: 1, d: 8'h00, exp_level: 14, exp_af: 0, exp_ae: 0};
    tbl[3] = '{af: 5'd16, ae: 5'd16, wr: 0, rd: 0, d: 8'h00, exp_level: 14, exp_af: 0, exp_ae: 1};
    tbl[4] = '{af: 5'd16, ae: 5'd13, wr: 0, rd: 1, d: 8'h00, exp_level: 13, exp_af: 0, exp_ae: 1};
    tbl[5] = '{af: 5'd14, ae: 5'd12, wr: 0, rd: 0, d: 8'h00, exp_level: 13, exp_af: 0, exp_ae: 0};
    tbl[6] = '{af: 5'd13, ae: 5'd31, wr: 0, rd: 0, d: 8'h00, exp_level: 13, exp_af: 1, exp_ae: 1};

    cycle(0, 8'h00, 0, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0, 1);
    chk("reset_empty", int'(f_empty), 1);
    chk("reset_reg_rd_data", int'(r_rd_data), 0);

    // Fill and overflow.
    for (int i = 1; i <= 16; i++) cycle(1, 8'(i), 0, 0, 0, 0);
    chk("fill_full", int'(f_full), 1);
    chk("fill_level", int'(f_level), 16);
    cycle(1, 8'hAA, 0, 0, 0, 0);
    chk("ovf_set", int'(f_ovf), 1);
    chk("ovf_level", int'(f_level), 16);

    // Drain in order, then underflow and clear.
    for (int i = 1; i <= 16; i++) begin
      chk("drain_head", int'(f_rd_data), i);
      cycle(0, 8'h00, 1, 0, 0, 0);
    end
    chk("drain_empty", int'(f_empty), 1);
    cycle(0, 8'h00, 1, 0, 0, 0);
    chk("udf_set", int'(f_udf), 1);
    chk("udf_level", int'(f_level), 0);
    cycle(0, 8'h00, 0, 0, 1, 0);
    chk("clr_ovf", int'(f_ovf), 0);
    chk("clr_udf", int'(f_udf), 0);
    chk("clr_peak", int'(f_peak), 0);
    cycle(0, 8'h00, 1, 0, 1, 0);
    chk("clr_vs_set", int'(f_udf), 1);

    // Registered read latency.
    cycle(1, 8'h5A, 0, 0, 0, 0);
    chk("reg_no_valid", int'(r_rd_valid), 0);
    cycle(0, 8'h00, 1, 0, 0, 0);
    chk("reg_valid", int'(r_rd_valid), 1);
    chk("reg_data", int'(r_rd_data), 8'h5A);
    cycle(0, 8'h00, 0, 0, 0, 0);
    chk("reg_valid_drop", int'(r_rd_valid), 0);
    chk("reg_data_hold", int'(r_rd_data), 8'h5A);

    // Simultaneous read/write at level 8 across the index wrap.
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h20 + i), 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 8'(8'h40 + i), 1, 0, 0, 0);
      chk("rw_level", int'(f_level), 8);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 8'h00, 1, 0, 0, 0);
      if (i == 6) chk("pfd_hold_l1", int'(f_pfd), 1);
    end
    chk("pfd_clear_l0", int'(f_pfd), 0);

    // Thresholds and pre-fill while filling to 14.
    for (int n = 1; n <= 14; n++) begin
      cycle(1, 8'(8'h60 + n), 0, 0, 0, 0);
      if (n == 2)  chk("ae_at2", int'(f_ae), 1);
      if (n == 3)  chk("ae_at3", int'(f_ae), 0);
      if (n == 8)  chk("pfd_at8", int'(f_pfd), 0);
      if (n == 9)  chk("pfd_after8", int'(f_pfd), 1);
      if (n == 13) chk("af_at13", int'(f_af), 0);
      if (n == 14) chk("af_at14", int'(f_af), 1);
    end
    for (int i = 0; i < 7; i++) begin
      af_thresh = tbl[i].af;
      ae_thresh = tbl[i].ae;
      cycle(tbl[i].wr, tbl[i].d, tbl[i].rd, 0, 0, 0);
      chk("tbl_level", int'(f_level), tbl[i].exp_level);
      chk("tbl_af", int'(f_af), int'(tbl[i].exp_af));
      chk("tbl_ae", int'(f_ae), int'(tbl[i].exp_ae));
    end
    af_thresh = 5'd14;
    ae_thresh = 5'd2;

    // Flush at level 10 with concurrent requests.
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0, 0, 0);
    chk("pre_flush_level", int'(f_level), 10);
    cycle(1, 8'h99, 1, 1, 0, 0);
    chk("flush_level", int'(f_level), 0);
    chk("flush_empty", int'(f_empty), 1);
    chk("flush_udf_kept", int'(f_udf), 1);
    chk("flush_peak_kept", int'(f_peak), 15);
    cycle(0, 8'h00, 0, 0, 0, 0);

    // Reset mid-stream at level 10.
    for (int i = 0; i < 10; i++) cycle(1, 8'(8'h80 + i), 0, 0, 0, 0);
    cycle(1, 8'h99, 0, 0, 0, 1);
    chk("rst_level", int'(f_level), 0);
    chk("rst_peak", int'(f_peak), 0);
    chk("rst_udf", int'(f_udf), 0);
    chk("rst_reg_rd_data", int'(r_rd_data), 0);
    cycle(1, 8'h11, 0, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0, 0);
    chk("post_rst_reg_data", int'(r_rd_data), 8'h11);
    cycle(0, 8'h00, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
